// File: rtl/ts_pcr_gen_if.sv
// MPEG-TS byte stream: sync marks byte 0, valid qualifies every packet byte.
interface ts_pcr_gen_if;
  logic       ts_sync;
  logic       ts_valid;
  logic [7:0] ts_data;

  modport master (output ts_sync, ts_valid, ts_data);
  modport slave  (input  ts_sync, ts_valid, ts_data);
endinterface

// File: rtl/ts_pcr_gen.sv
// Round-robin multi-PID MPEG-TS packet source with periodic PCR adaptation fields.
// Byte 0 one cycle after gen_ena is seen at a boundary; no backpressure, gen_ena only gates packet starts.
module ts_pcr_gen #(
  parameter int          CH_NUM     = 4,
  parameter logic [12:0] BASE_PID   = 13'h100,
  parameter int          PKT_GAP    = 4,
  parameter int          PCR_PERIOD = 8,
  parameter int          PCR_TICK   = 1,
  parameter logic [41:0] PCR_INIT   = 42'd0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gen_ena,
  ts_pcr_gen_if.master  ts,
  output logic [31:0]   pkt_cnt
);

  localparam int PW = (PCR_PERIOD > 1) ? $clog2(PCR_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    idx, idx_nxt;
  logic [15:0]   gap_cnt, gap_nxt;
  logic [3:0]    ch, ch_nxt;
  logic          pkt_end, boundary;
  logic [3:0]    cc [16];
  logic [PW-1:0] per_cnt [16];
  logic [32:0]   pcr_base, base_n, snap_base;
  logic [8:0]    pcr_ext, ext_n, snap_ext;
  logic [9:0]    ext_sum;
  logic          sync_nxt, valid_nxt, pcr_pkt;
  logic [7:0]    data_nxt;
  logic [12:0]   pid;

  always_comb begin
    ext_sum = {1'b0, pcr_ext} + 10'(PCR_TICK);
    if (ext_sum >= 10'd300) begin
      ext_n  = 9'(ext_sum - 10'd300);
      base_n = pcr_base + 33'd1;
    end else begin
      ext_n  = ext_sum[8:0];
      base_n = pcr_base;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    gap_nxt   = gap_cnt;
    pkt_end   = 1'b0;
    boundary  = 1'b0;
    case (state)
      IDLE: begin
        if (gen_ena) begin
          state_nxt = SEND;
          idx_nxt   = 8'd0;
        end
      end
      SEND: begin
        if (idx == 8'd187) begin
          pkt_end = 1'b1;
          if (PKT_GAP > 0) begin
            state_nxt = GAP;
            gap_nxt   = 16'd0;
          end else begin
            boundary = 1'b1;
          end
        end else begin
          idx_nxt = idx + 8'd1;
        end
      end
      GAP: begin
        if (gap_cnt == 16'(PKT_GAP - 1)) boundary = 1'b1;
        else                             gap_nxt  = gap_cnt + 16'd1;
      end
      default: state_nxt = IDLE;
    endcase
    if (boundary) begin
      state_nxt = gen_ena ? SEND : IDLE;
      idx_nxt   = 8'd0;
    end
    ch_nxt = ch;
    if (pkt_end) ch_nxt = (ch == 4'(CH_NUM - 1)) ? 4'd0 : ch + 4'd1;
  end

  // Decode the byte for the upcoming cycle so the stream leaves straight from flops.
  // Header/PCR fields are only read from idx 1 on, after end-of-packet updates have settled.
  always_comb begin
    pid       = BASE_PID + {9'd0, ch_nxt};
    pcr_pkt   = (per_cnt[ch_nxt] == '0);
    sync_nxt  = 1'b0;
    valid_nxt = 1'b0;
    data_nxt  = 8'h00;
    if (state_nxt == SEND) begin
      valid_nxt = 1'b1;
      sync_nxt  = (idx_nxt == 8'd0);
      case (idx_nxt)
        8'd0: data_nxt = 8'h47;
        8'd1: data_nxt = {3'b000, pid[12:8]};
        8'd2: data_nxt = pid[7:0];
        8'd3: data_nxt = {2'b00, (pcr_pkt ? 2'b11 : 2'b01), cc[ch_nxt]};
        default: begin
          data_nxt = idx_nxt ^ {4'h0, ch_nxt};
          if (pcr_pkt) begin
            case (idx_nxt)
              8'd4:  data_nxt = 8'h07;
              8'd5:  data_nxt = 8'h10;
              8'd6:  data_nxt = snap_base[32:25];
              8'd7:  data_nxt = snap_base[24:17];
              8'd8:  data_nxt = snap_base[16:9];
              8'd9:  data_nxt = snap_base[8:1];
              8'd10: data_nxt = {snap_base[0], 6'h3F, snap_ext[8]};
              8'd11: data_nxt = snap_ext[7:0];
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 8'd0;
      gap_cnt   <= 16'd0;
      ch        <= 4'd0;
      pkt_cnt   <= 32'd0;
      pcr_base  <= PCR_INIT[41:9];
      pcr_ext   <= PCR_INIT[8:0];
      snap_base <= 33'd0;
      snap_ext  <= 9'd0;
      for (int i = 0; i < 16; i++) begin
        cc[i]      <= 4'd0;
        per_cnt[i] <= '0;
      end
      ts.ts_sync  <= 1'b0;
      ts.ts_valid <= 1'b0;
      ts.ts_data  <= 8'h00;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      gap_cnt  <= gap_nxt;
      ch       <= ch_nxt;
      pcr_base <= base_n;
      pcr_ext  <= ext_n;
      // Snapshot equals the counter value visible while byte 0 is on the bus.
      if (state_nxt == SEND && idx_nxt == 8'd0) begin
        snap_base <= base_n;
        snap_ext  <= ext_n;
      end
      if (pkt_end) begin
        pkt_cnt     <= pkt_cnt + 32'd1;
        cc[ch]      <= cc[ch] + 4'd1;
        per_cnt[ch] <= (per_cnt[ch] == PW'(PCR_PERIOD - 1)) ? '0 : per_cnt[ch] + PW'(1);
      end
      ts.ts_sync  <= sync_nxt;
      ts.ts_valid <= valid_nxt;
      ts.ts_data  <= data_nxt;
    end
  end

endmodule
